vigenere_cipher_stream: RTL and testbench
=========================================

# vigenere_cipher_stream

Streaming Vigenère cipher engine, the parametrised successor to the team's single-shift Caesar cipher block. A key of 1..MAX_KEY_LEN letters is loaded serially into an internal key RAM. Each accepted letter is shifted by the current key letter, and the key index advances and wraps automatically. The block sits between a byte-stream source and sink, with valid/ready handshakes on both sides and a one-entry registered output stage.

## Interface
- MAX_KEY_LEN, 16, maximum key length in characters; legal range 2..256. IDX_W = $clog2(MAX_KEY_LEN).
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- key_wr_valid  in  1  key character strobe.
- key_wr_char  in  8  key character (ASCII 'A'-'Z' or 'a'-'z').
- key_wr_last  in  1  marks final key character; qualified by key_wr_valid.
- key_rewind  in  1  synchronous pulse; forces key index to 0.
- key_err  out  1  sticky; set on invalid key char or key overflow.
- key_len  out  IDX_W+1  length of the active key; 0 when no key is loaded.
- in_valid  in  1  plaintext/ciphertext char valid.
- in_ready  out  1  block accepts in_char this cycle.
- in_char  in  8  input ASCII char.
- in_dir  in  1  0 = encrypt (right shift), 1 = decrypt (left shift); sampled per accepted char.
- out_valid  out  1  out_char/out_err valid.
- out_ready  in  1  sink accepts output.
- out_char  out  8  result char.
- out_err  out  1  accepted char was not a letter.

## Operation
- FSM states:
  - S_NOKEY (reset state): in_ready=0.
  - S_LOAD: in_ready=0.
  - S_RUN.
- Key load:
  - key_wr_valid in S_NOKEY or S_RUN: write char to key[0], wr_ptr=1, clear key_err, go to S_LOAD.
  - In S_LOAD, each key_wr_valid writes key[wr_ptr] and increments wr_ptr.
  - key_wr_last with a valid char: key_len=wr_ptr+1, key index=0, go to S_RUN. A single-cycle load (valid+last in S_NOKEY/S_RUN) gives key_len=1.
  - Shift value = char-'A' for upper case, char-'a' for lower case, range 0..25; shifts are stored as 5-bit values.
  - Invalid key char: key_err=1, key_len=0, go to S_NOKEY.
  - Writing beyond MAX_KEY_LEN characters: key_err=1, key_len=0, go to S_NOKEY.
  - Entering S_LOAD from S_RUN invalidates the old key: key_len=0 until key_wr_last. A char already in the output register is still presented.
- Data path, in S_RUN only:
  - Handshake: in_ready = (state==S_RUN) && (!out_valid || out_ready). A transfer occurs when in_valid && in_ready.
  - Letter, encrypt: off = char - base; r = off + k; if r ≥ 26 then r -= 26; out_char = base + r. base is 'A' or 'a', so case is preserved.
  - Letter, decrypt: r = off - k; if r < 0 then r += 26.
  - After each accepted letter the key index advances: idx = (idx == key_len-1) ? 0 : idx+1.
  - Non-letters do not advance idx; output per Configuration.
  - key_rewind: idx=0. If a char is accepted in the same cycle, that char uses key[0] and idx becomes 1 (or stays 0 when key_len=1).
- Output register:
  - Loaded on every transfer.
  - out_valid cleared on out_ready when no new transfer occurs.
  - out_char/out_err held stable while out_valid && !out_ready.

## Timing
- Latency: 1 cycle from input transfer to out_valid. Throughput: 1 char per cycle when out_ready=1.
- Key load takes N cycles for an N-char key; the first data char is accepted the cycle after key_wr_last.
- Reset values: in_ready=0, out_valid=0, out_char=8'h00, out_err=0, key_err=0, key_len=0, state S_NOKEY, idx=0, wr_ptr=0. Key RAM contents are don't-care.
- Reset mid-stream drops any pending output immediately (asynchronous). A new key must be loaded after reset.
- key_wr_valid has priority over data: a key write in S_RUN deasserts in_ready in the following cycle. A data transfer in the same cycle as the key write still completes using the old key.

## Configuration
- VIGENERE_PASSTHROUGH_EN defined: non-letters emit out_char = in_char unchanged, out_err=0.
- VIGENERE_PASSTHROUGH_EN undefined: non-letters emit out_char=8'h00, out_err=1.
- In both cases the key index does not advance on non-letters.

## Test plan
- Key "LEMON", encrypt "ATTACKATDAWN", out_ready=1 → "LXFOPVEFRNHR", one char per cycle, first output 1 cycle after the first accept.
- Key "LEMON", decrypt "LXFOPVEFRNHR" → "ATTACKATDAWN". Same key in lower case, encrypt "attack" → "lxfopv".
- Key "BC", encrypt 'A','-','A':
  - Without macro → 'B', 8'h00 with out_err=1, 'C'.
  - With macro → 'B', '-' with out_err=0, 'C'.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream → in_ready=0 after the first output, out_char stable, no chars lost or duplicated after release.
- Key errors:
  - Key "A1" → key_err=1, key_len=0, in_ready=0.
  - 17 chars with MAX_KEY_LEN=16 → key_err=1.
  - Reloading a valid key → key_err=0 at the first key write.
- Assert rst_n low mid-stream with out_valid=1 → out_valid=0 and out_char=8'h00 immediately, in_ready=0 until a key is reloaded. key_rewind after 3 letters with key "LEMON" → next letter uses 'L'.

Source files
------------

// File: rtl/vigenere_cipher_stream_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vigenere_cipher_stream_if
// Description : Key-load and byte-stream handshake bundle for the streaming
//               Vigenere cipher engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface vigenere_cipher_stream_if #(
  parameter int MAX_KEY_LEN = 16
);
  localparam int IDX_W = $clog2(MAX_KEY_LEN);

  // Key load channel
  logic             key_wr_valid;
  logic [7:0]       key_wr_char;
  logic             key_wr_last;
  logic             key_rewind;
  logic             key_err;
  logic [IDX_W:0]   key_len;

  // Input stream
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_char;
  logic             in_dir;

  // Output stream
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_char;
  logic             out_err;

  // Source/sink side
  modport master (
    output key_wr_valid, key_wr_char, key_wr_last, key_rewind,
    output in_valid, in_char, in_dir, out_ready,
    input  key_err, key_len, in_ready, out_valid, out_char, out_err
  );

  // Cipher engine side
  modport slave (
    input  key_wr_valid, key_wr_char, key_wr_last, key_rewind,
    input  in_valid, in_char, in_dir, out_ready,
    output key_err, key_len, in_ready, out_valid, out_char, out_err
  );
endinterface
`default_nettype wire

// File: rtl/vigenere_cipher_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vigenere_cipher_stream
// Description : Streaming Vigenere cipher. A 1..MAX_KEY_LEN letter key is
//               loaded serially into a key RAM; each accepted letter is
//               shifted by the current key letter (encrypt right / decrypt
//               left) and the key index wraps automatically. One-entry
//               registered output stage with valid/ready on both sides.
//               Optional macro VIGENERE_PASSTHROUGH_EN: non-letters pass
//               through unchanged instead of being flagged with out_err.
// Revision    : 1.0 - initial release
// ============================================================================
module vigenere_cipher_stream #(
  parameter int MAX_KEY_LEN = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  vigenere_cipher_stream_if.slave   bus
);

  localparam int IDX_W = $clog2(MAX_KEY_LEN);

  localparam logic [1:0] S_NOKEY = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  localparam logic [IDX_W:0]   c_MAX_LEN = (IDX_W+1)'(MAX_KEY_LEN);
  localparam logic [IDX_W:0]   c_LEN_ONE = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] c_IDX_ONE = IDX_W'(1);

  // Registered state
  logic [1:0]       r_state;
  logic [IDX_W:0]   r_wr_ptr;
  logic [IDX_W:0]   r_key_len;
  logic             r_key_err;
  logic [IDX_W-1:0] r_idx;
  logic             r_out_valid;
  logic [7:0]       r_out_char;
  logic             r_out_err;
  logic [4:0]       r_key [MAX_KEY_LEN];

  // Key-side combinational
  logic             w_key_ok;
  logic [4:0]       w_key_shift;
  logic             w_key_first;
  logic             w_key_ovf;
  logic             w_key_bad;
  logic             w_key_we;
  logic [IDX_W-1:0] w_key_addr;
  logic [IDX_W:0]   w_wr_ptr_cur;

  // Data-side combinational
  logic             w_in_ready;
  logic             w_xfer;
  logic             w_in_letter;
  logic [IDX_W-1:0] w_use_idx;
  logic [4:0]       w_k;
  logic [4:0]       w_off;
  logic [5:0]       w_sum;
  logic [4:0]       w_enc;
  logic [4:0]       w_dec;
  logic [4:0]       w_res;
  logic [7:0]       w_letter_char;
  logic             w_idx_wrap;
  logic [IDX_W-1:0] w_idx_next;
  logic [7:0]       w_res_char;
  logic             w_res_err;

  function automatic logic f_is_letter(input logic [7:0] c);
    return ((c >= 8'h41) && (c <= 8'h5A)) || ((c >= 8'h61) && (c <= 8'h7A));
  endfunction

  // ---------------------------------------------------------------------
  // Key load decode
  // ---------------------------------------------------------------------
  // 'A' (0x41) and 'a' (0x61) both have 5'd1 in their low five bits, so the
  // alphabet offset of either case is simply char[4:0] - 1.
  assign w_key_ok     = f_is_letter(bus.key_wr_char);
  assign w_key_shift  = bus.key_wr_char[4:0] - 5'd1;
  assign w_key_first  = (r_state != S_LOAD);
  assign w_key_ovf    = (r_state == S_LOAD) && (r_wr_ptr == c_MAX_LEN);
  assign w_key_bad    = !w_key_ok || w_key_ovf;
  assign w_key_we     = bus.key_wr_valid && !w_key_bad;
  assign w_wr_ptr_cur = w_key_first ? '0 : r_wr_ptr;
  assign w_key_addr   = w_wr_ptr_cur[IDX_W-1:0];

  // ---------------------------------------------------------------------
  // Cipher datapath
  // ---------------------------------------------------------------------
  assign w_in_ready  = (r_state == S_RUN) && (!r_out_valid || bus.out_ready);
  assign w_xfer      = bus.in_valid && w_in_ready;
  assign w_in_letter = f_is_letter(bus.in_char);

  // A rewind in the same cycle as an accepted char makes that char use key[0].
  assign w_use_idx = bus.key_rewind ? '0 : r_idx;
  assign w_k       = r_key[w_use_idx];
  assign w_off     = bus.in_char[4:0] - 5'd1;
  assign w_sum     = {1'b0, w_off} + {1'b0, w_k};
  assign w_enc     = (w_sum >= 6'd26) ? 5'(w_sum - 6'd26) : w_sum[4:0];
  // Modulo-32 wrap of the intermediate is harmless: the final result is 0..25.
  assign w_dec     = (w_off >= w_k) ? (w_off - w_k) : (w_off + 5'd26 - w_k);
  assign w_res     = bus.in_dir ? w_dec : w_enc;
  // Upper three bits carry the case (base 0x40 / 0x60); re-add the +1 offset.
  assign w_letter_char = {bus.in_char[7:5], w_res + 5'd1};

  assign w_idx_wrap = ({1'b0, w_use_idx} == (r_key_len - c_LEN_ONE));
  assign w_idx_next = w_idx_wrap ? '0 : (w_use_idx + c_IDX_ONE);

`ifdef VIGENERE_PASSTHROUGH_EN
  assign w_res_char = w_in_letter ? w_letter_char : bus.in_char;
  assign w_res_err  = 1'b0;
`else
  assign w_res_char = w_in_letter ? w_letter_char : 8'h00;
  assign w_res_err  = !w_in_letter;
`endif

  // Key RAM: contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clk) begin
    if (w_key_we) begin
      r_key[w_key_addr] <= w_key_shift;
    end
  end

  // Control FSM: key load sequencing, key length, error flag and key index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_NOKEY;
      r_wr_ptr  <= '0;
      r_key_len <= '0;
      r_key_err <= 1'b0;
      r_idx     <= '0;
    end else begin
      r_idx <= (w_xfer && w_in_letter) ? w_idx_next : w_use_idx;
      // Key writes take priority; a data char in this cycle used the old key.
      if (bus.key_wr_valid) begin
        if (w_key_bad) begin
          r_key_err <= 1'b1;
          r_key_len <= '0;
          r_wr_ptr  <= '0;
          r_state   <= S_NOKEY;
        end else begin
          if (w_key_first) begin
            r_key_err <= 1'b0;
          end
          r_wr_ptr <= w_wr_ptr_cur + c_LEN_ONE;
          if (bus.key_wr_last) begin
            r_key_len <= w_wr_ptr_cur + c_LEN_ONE;
            r_idx     <= '0;
            r_state   <= S_RUN;
          end else begin
            r_key_len <= '0;
            r_state   <= S_LOAD;
          end
        end
      end
    end
  end

  // One-entry output register: load on transfer, drop valid once consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_char  <= 8'h00;
      r_out_err   <= 1'b0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_char  <= w_res_char;
      r_out_err   <= w_res_err;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_char  = r_out_char;
  assign bus.out_err   = r_out_err;
  assign bus.key_err   = r_key_err;
  assign bus.key_len   = r_key_len;

endmodule
`default_nettype wire

// File: tb/tb_vigenere_cipher_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_vigenere_cipher_stream
// Description : Scoreboard bench for vigenere_cipher_stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vigenere_cipher_stream;
  localparam int MAX_KEY_LEN = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   first_acc = 0;

  logic [8:0] sb_exp[$];
  logic [8:0] cap[$];
  int         cap_t[$];

  vigenere_cipher_stream_if #(.MAX_KEY_LEN(MAX_KEY_LEN)) bus();

  vigenere_cipher_stream #(.MAX_KEY_LEN(MAX_KEY_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every output handshake with the cycle stamp it completes on
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      cap.push_back({bus.out_err, bus.out_char});
      cap_t.push_back(cyc);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Reference cipher using plain modular arithmetic
  function automatic logic [8:0] f_model(input logic [7:0] c, input logic [7:0] kc, input bit dir);
    int off, k, r;
    logic [7:0] base;
    if (c >= 8'h41 && c <= 8'h5A) base = 8'h41;
    else if (c >= 8'h61 && c <= 8'h7A) base = 8'h61;
    else begin
`ifdef VIGENERE_PASSTHROUGH_EN
      return {1'b0, c};
`else
      return {1'b1, 8'h00};
`endif
    end
    k   = (kc >= 8'h61) ? int'(kc) - 8'h61 : int'(kc) - 8'h41;
    off = int'(c) - int'(base);
    r   = dir ? (off - k + 26) % 26 : (off + k) % 26;
    return {1'b0, 8'(int'(base) + r)};
  endfunction

  task automatic push_str(input string s, input bit err);
    for (int i = 0; i < s.len(); i++) sb_exp.push_back({err, s[i]});
  endtask

  task automatic clear_caps();
    cap.delete();
    cap_t.delete();
    sb_exp.delete();
  endtask

  task automatic load_key(input string k);
    for (int i = 0; i < k.len(); i++) begin
      bus.key_wr_valid = 1'b1;
      bus.key_wr_char  = k[i];
      bus.key_wr_last  = (i == k.len() - 1);
      @(posedge clk); #1;
    end
    bus.key_wr_valid = 1'b0;
    bus.key_wr_last  = 1'b0;
  endtask

  task automatic send_char(input logic [7:0] c, input bit dir);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_char  = c;
    bus.in_dir   = dir;
    for (int t = 0; t < 100 && !done; t++) begin
      @(negedge clk);
      done = bus.in_ready;
      @(posedge clk); #1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted char=%h", c);
    end
  endtask

  task automatic send_str(input string s, input bit dir);
    for (int i = 0; i < s.len(); i++) begin
      send_char(s[i], dir);
      if (i == 0) first_acc = cyc;
    end
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready actual=%b required=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid actual=%b required=0", bus.out_valid); end
    checks++; if (bus.out_char !== 8'h00) begin failures++; $display("FAIL reset_out_char actual=%h required=00", bus.out_char); end
    checks++; if (bus.out_err !== 1'b0) begin failures++; $display("FAIL reset_out_err actual=%b required=0", bus.out_err); end
    checks++; if (bus.key_err !== 1'b0) begin failures++; $display("FAIL reset_key_err actual=%b required=0", bus.key_err); end
    checks++; if (bus.key_len !== 5'd0) begin failures++; $display("FAIL reset_key_len actual=%0d required=0", bus.key_len); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_encrypt();
    int n;
    logic [8:0] e, a;
    clear_caps();
    load_key("LEMON");
    checks++; if (bus.key_len !== 5'd5) begin failures++; $display("FAIL enc_key_len actual=%0d required=5", bus.key_len); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL enc_ready_after_load actual=%b required=1", bus.in_ready); end
    push_str("LXFOPVEFRNHR", 1'b0);
    n = sb_exp.size();
    send_str("ATTACKATDAWN", 1'b0);
    checks++; if (cap.size() !== n) begin failures++; $display("FAIL enc_count actual=%0d required=%0d", cap.size(), n); end
    if (cap_t.size() == n) begin
      checks++; if (cap_t[0] !== first_acc) begin failures++; $display("FAIL enc_latency actual=%0d required=%0d", cap_t[0], first_acc); end
      checks++; if (cap_t[n-1] - cap_t[0] !== n - 1) begin failures++; $display("FAIL enc_throughput actual=%0d required=%0d", cap_t[n-1] - cap_t[0], n - 1); end
    end
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front();
      a = (cap.size() > 0) ? cap.pop_front() : 9'bx;
      checks++; if (a !== e) begin failures++; $display("FAIL enc_char actual=%h required=%h", a, e); end
    end
  endtask

  task automatic test_decrypt_and_case();
    logic [8:0] e, a;
    int n;
    clear_caps();
    // Reload from S_RUN: the first key write must block the data side
    bus.key_wr_valid = 1'b1; bus.key_wr_char = 8'h4C; bus.key_wr_last = 1'b0;
    @(posedge clk); #1;
    bus.key_wr_valid = 1'b0;
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reload_in_ready actual=%b required=0", bus.in_ready); end
    checks++; if (bus.key_len !== 5'd0) begin failures++; $display("FAIL reload_key_len actual=%0d required=0", bus.key_len); end
    load_key("EMON");
    push_str("ATTACKATDAWN", 1'b0);
    send_str("LXFOPVEFRNHR", 1'b1);
    load_key("lemon");
    push_str("lxfopv", 1'b0);
    n = sb_exp.size();
    send_str("attack", 1'b0);
    checks++; if (cap.size() !== n) begin failures++; $display("FAIL dec_count actual=%0d required=%0d", cap.size(), n); end
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front();
      a = (cap.size() > 0) ? cap.pop_front() : 9'bx;
      checks++; if (a !== e) begin failures++; $display("FAIL dec_char actual=%h required=%h", a, e); end
    end
  endtask

  task automatic test_nonletter();
    logic [8:0] e, a;
    int n;
    clear_caps();
    load_key("BC");
    sb_exp.push_back({1'b0, 8'h42});
`ifdef VIGENERE_PASSTHROUGH_EN
    sb_exp.push_back({1'b0, 8'h2D});
`else
    sb_exp.push_back({1'b1, 8'h00});
`endif
    sb_exp.push_back({1'b0, 8'h43});
    n = sb_exp.size();
    send_str("A-A", 1'b0);
    checks++; if (cap.size() !== n) begin failures++; $display("FAIL nl_count actual=%0d required=%0d", cap.size(), n); end
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front();
      a = (cap.size() > 0) ? cap.pop_front() : 9'bx;
      checks++; if (a !== e) begin failures++; $display("FAIL nl_char actual=%h required=%h", a, e); end
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] e, a;
    logic [7:0] held;
    string key, pt;
    int n;
    clear_caps();
    key = "LEMON";
    pt  = "ATTACKATDAWN";
    load_key(key);
    for (int i = 0; i < pt.len(); i++) sb_exp.push_back(f_model(pt[i], key[i % 5], 1'b0));
    n = sb_exp.size();
    fork
      send_str(pt, 1'b0);
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        held = bus.out_char;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready actual=%b required=0", bus.in_ready); end
          checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid actual=%b required=1", bus.out_valid); end
          checks++; if (bus.out_char !== held) begin failures++; $display("FAIL bp_out_stable actual=%h required=%h", bus.out_char, held); end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    checks++; if (cap.size() !== n) begin failures++; $display("FAIL bp_count actual=%0d required=%0d", cap.size(), n); end
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front();
      a = (cap.size() > 0) ? cap.pop_front() : 9'bx;
      checks++; if (a !== e) begin failures++; $display("FAIL bp_char actual=%h required=%h", a, e); end
    end
  endtask

  task automatic test_key_errors();
    load_key("A1");
    checks++; if (bus.key_err !== 1'b1) begin failures++; $display("FAIL kerr_bad_err actual=%b required=1", bus.key_err); end
    checks++; if (bus.key_len !== 5'd0) begin failures++; $display("FAIL kerr_bad_len actual=%0d required=0", bus.key_len); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL kerr_bad_ready actual=%b required=0", bus.in_ready); end
    load_key("ABCDEFGHIJKLMNOPQ");
    checks++; if (bus.key_err !== 1'b1) begin failures++; $display("FAIL kerr_ovf_err actual=%b required=1", bus.key_err); end
    checks++; if (bus.key_len !== 5'd0) begin failures++; $display("FAIL kerr_ovf_len actual=%0d required=0", bus.key_len); end
    bus.key_wr_valid = 1'b1; bus.key_wr_char = 8'h42; bus.key_wr_last = 1'b0;
    @(posedge clk); #1;
    bus.key_wr_valid = 1'b0;
    checks++; if (bus.key_err !== 1'b0) begin failures++; $display("FAIL kerr_clear actual=%b required=0", bus.key_err); end
    load_key("C");
    checks++; if (bus.key_len !== 5'd2) begin failures++; $display("FAIL kerr_reload_len actual=%0d required=2", bus.key_len); end
    load_key("ABCDEFGHIJKLMNOP");
    checks++; if (bus.key_len !== 5'd16) begin failures++; $display("FAIL kerr_max_len actual=%0d required=16", bus.key_len); end
    checks++; if (bus.key_err !== 1'b0) begin failures++; $display("FAIL kerr_max_err actual=%b required=0", bus.key_err); end
  endtask

  task automatic test_reset_midstream();
    clear_caps();
    load_key("LEMON");
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_char   = 8'h41;
    bus.in_dir    = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL rst_pre_valid actual=%b required=1", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_async_valid actual=%b required=0", bus.out_valid); end
    checks++; if (bus.out_char !== 8'h00) begin failures++; $display("FAIL rst_async_char actual=%h required=00", bus.out_char); end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_async_ready actual=%b required=0", bus.in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_nokey_ready actual=%b required=0", bus.in_ready); end
    checks++; if (bus.key_len !== 5'd0) begin failures++; $display("FAIL rst_nokey_len actual=%0d required=0", bus.key_len); end
    bus.in_valid = 1'b0;
    clear_caps();
  endtask

  task automatic test_rewind();
    logic [8:0] e, a;
    int n;
    clear_caps();
    load_key("LEMON");
    push_str("LEMLLE", 1'b0);
    n = sb_exp.size();
    send_str("AAA", 1'b0);
    bus.key_rewind = 1'b1;
    @(posedge clk); #1;
    bus.key_rewind = 1'b0;
    send_str("A", 1'b0);
    bus.key_rewind = 1'b1;
    send_char(8'h41, 1'b0);
    bus.key_rewind = 1'b0;
    send_char(8'h41, 1'b0);
    bus.in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (cap.size() !== n) begin failures++; $display("FAIL rew_count actual=%0d required=%0d", cap.size(), n); end
    while (sb_exp.size() > 0) begin
      e = sb_exp.pop_front();
      a = (cap.size() > 0) ? cap.pop_front() : 9'bx;
      checks++; if (a !== e) begin failures++; $display("FAIL rew_char actual=%h required=%h", a, e); end
    end
  endtask

  initial begin
    bus.key_wr_valid = 1'b0;
    bus.key_wr_char  = 8'h00;
    bus.key_wr_last  = 1'b0;
    bus.key_rewind   = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_char      = 8'h00;
    bus.in_dir       = 1'b0;
    bus.out_ready    = 1'b1;

    test_reset();
    test_encrypt();
    test_decrypt_and_case();
    test_nonletter();
    test_backpressure();
    test_key_errors();
    test_reset_midstream();
    test_rewind();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
